// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order
// fetches, buffers words in a small FIFO toward decode.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;

  logic [31:0] tag_q   [BUF_DEPTH];
  logic [31:0] tag_d   [BUF_DEPTH];
  logic [31:0] instr_q [BUF_DEPTH];
  logic [31:0] instr_d [BUF_DEPTH];
  logic [31:0] ipc_q   [BUF_DEPTH];
  logic [31:0] ipc_d   [BUF_DEPTH];

  logic        pop;
  logic        rv;
  logic        gnt_ok;
  logic        push;
  logic [CW:0] credit;

  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  // FSM output side: request credit and FIFO head view
  always_comb begin
    out_valid = (cnt_q != '0);
    pop       = out_valid && out_ready;
    credit    = {1'b0, outst_q} + {1'b0, cnt_q}
              - (CW+1)'(pop);
    mem_req   = (state_q != BOOT) && !redirect_valid
              && (credit < (CW+1)'(BUF_DEPTH));
    mem_addr  = pc_q;
    out_instr     = out_valid ? instr_q[rd_q] : '0;
    out_pc        = out_valid ? ipc_q[rd_q] : '0;
    out_pc_plus_4 = out_valid ? ipc_q[rd_q] + 32'd4 : '0;
  end

  // memory handshake qualifiers; a stray rvalid is ignored
  always_comb begin
    rv     = mem_rvalid && (outst_q != '0);
    gnt_ok = mem_req && mem_gnt;
    push   = rv && (drop_q == '0) && !redirect_valid;
  end

  // PC, outstanding/drop counters and tag queue
  always_comb begin
    pc_d     = pc_q;
    outst_d  = outst_q + CW'(gnt_ok) - CW'(rv);
    drop_d   = drop_q;
    tag_wr_d = tag_wr_q + AW'(gnt_ok);
    tag_rd_d = tag_rd_q + AW'(rv);
    tag_d    = tag_q;
    if (gnt_ok) begin
      tag_d[tag_wr_q] = pc_q;
    end
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = outst_d;
    end else begin
      if (gnt_ok) begin
        pc_d = pc_q + 32'd4;
      end
      if (rv && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  // instruction FIFO; a redirect empties it outright
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (redirect_valid) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        instr_d[wr_q] = mem_rdata;
        ipc_d[wr_q]   = tag_q[tag_rd_q];
        wr_d          = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // next state: DRAIN while dropped responses remain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (drop_d != '0) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // storage arrays, qualified by the counters above
  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    instr_q <= instr_d;
    ipc_q   <= ipc_d;
  end

  a_no_stray_rvalid: assert property (
    @(posedge clk) disable iff (reset)
    mem_rvalid |-> (outst_q != '0)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: vector table, corner
// sequences and random traffic against a queue model.
module tb_instr_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;

  instr_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] pc;
    bit          dropped;
  } tag_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rdy;
    bit          ereq;
    logic [31:0] eaddr;
    bit          evld;
    logic [31:0] epc;
  } vec_t;

  rsp_t        rq[$];
  tag_t        mtag[$];
  ent_t        mfifo[$];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          cur_rv;
  int          cyc;
  int          lat;
  int          n_tests;
  int          n_fail;
  vec_t        tbl[25];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(
    input bit rst, input bit gnt, input bit rdy,
    input bit ereq, input logic [31:0] ea,
    input bit ev, input logic [31:0] ep);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rdy = rdy;
    v.ereq = ereq; v.eaddr = ea;
    v.evld = ev; v.epc = ep;
    return v;
  endfunction

  task automatic chk32(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // drive one cycle, check against the model, update it
  task automatic drive_check(input bit redir,
                             input logic [31:0] rpc,
                             input bit gnt, input bit rdy);
    bit   evld;
    bit   pop;
    bit   ereq;
    int   held;
    tag_t t;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_gnt        = gnt;
    out_ready      = rdy;
    cur_rv = (rq.size() > 0) && (rq[0].due <= cyc);
    mem_rvalid = cur_rv;
    mem_rdata  = cur_rv ? memfn(rq[0].addr) : $urandom;
    #2;
    evld = mfifo.size() > 0;
    pop  = evld && rdy;
    held = mtag.size() + mfifo.size() - (pop ? 1 : 0);
    ereq = !m_boot && !redir && (held < DEPTH);
    chk1("m out_valid", out_valid, evld);
    if (evld) begin
      chk32("m out_pc", out_pc, mfifo[0].pc);
      chk32("m out_instr", out_instr, mfifo[0].instr);
      chk32("m out_pc_plus_4", out_pc_plus_4,
            mfifo[0].pc + 32'd4);
    end
    chk1("m mem_req", mem_req, ereq);
    if (ereq) chk32("m mem_addr", mem_addr, m_pc);
    if (mem_req && mem_gnt)
      rq.push_back('{mem_addr, cyc + lat});
    if (pop && !redir) void'(mfifo.pop_front());
    if (cur_rv && mtag.size() > 0) begin
      t = mtag.pop_front();
      if (!t.dropped && !redir)
        mfifo.push_back('{mem_rdata, t.pc});
    end
    if (cur_rv) void'(rq.pop_front());
    if (redir) begin
      mfifo.delete();
      foreach (mtag[i]) mtag[i].dropped = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else if (ereq && gnt) begin
      mtag.push_back('{m_pc, 1'b0});
      m_pc += 32'd4;
    end
    m_boot = 1'b0;
  endtask

  // hold reset; responses still in flight keep arriving
  task automatic do_reset(input int n);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mem_gnt        = 1'b0;
    out_ready      = 1'b0;
    for (int i = 0; i < n; i++) begin
      cur_rv     = rq.size() > 0;
      mem_rvalid = cur_rv;
      mem_rdata  = cur_rv ? memfn(rq[0].addr) : 32'h0;
      #2;
      if (i > 0) begin
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst out_valid", out_valid, 1'b0);
        chk32("rst out_instr", out_instr, 32'h0);
        chk32("rst out_pc", out_pc, 32'h0);
        chk32("rst out_pc_plus_4", out_pc_plus_4, 32'h0);
      end
      if (cur_rv) void'(rq.pop_front());
      tick();
    end
    reset      = 1'b0;
    mem_rvalid = 1'b0;
    rq.delete();
    mtag.delete();
    mfifo.delete();
    m_pc   = 32'h0;
    m_boot = 1'b1;
  endtask

  task automatic wait_valid(input string name,
                            input logic [31:0] pc,
                            input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      drive_check(1'b0, 32'h0, 1'b1, 1'b1);
      if (out_valid) begin
        found = 1'b1;
        chk32({name, " pc"}, out_pc, pc);
        chk32({name, " instr"}, out_instr, memfn(pc));
      end
      tick();
    end
    chk1({name, " seen"}, found, 1'b1);
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) begin
      drive_check(1'b0, 32'h0, 1'b1, 1'b1);
      tick();
    end
  endtask

  initial begin
    bit          r;
    logic [31:0] rpc;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    lat     = 1;
    m_pc    = 32'h0;
    m_boot  = 1'b1;

    // streaming, then a 5-cycle decode stall
    tbl[0]  = mk(1, 1, 1, 0, 32'h00, 0, 32'h00);
    tbl[1]  = mk(0, 1, 1, 1, 32'h00, 0, 32'h00);
    tbl[2]  = mk(0, 1, 1, 1, 32'h04, 0, 32'h00);
    tbl[3]  = mk(0, 1, 1, 1, 32'h08, 1, 32'h00);
    tbl[4]  = mk(0, 1, 1, 1, 32'h0C, 1, 32'h04);
    tbl[5]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h08);
    tbl[6]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h08);
    tbl[7]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h08);
    tbl[8]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h08);
    tbl[9]  = mk(0, 1, 0, 0, 32'h00, 1, 32'h08);
    tbl[10] = mk(0, 1, 1, 1, 32'h10, 1, 32'h08);
    tbl[11] = mk(0, 1, 1, 1, 32'h14, 1, 32'h0C);
    tbl[12] = mk(0, 1, 1, 1, 32'h18, 1, 32'h10);
    tbl[13] = mk(0, 1, 1, 1, 32'h1C, 1, 32'h14);
    // grant withheld for 3 cycles at 0xC
    tbl[14] = mk(1, 1, 1, 0, 32'h00, 0, 32'h00);
    tbl[15] = mk(0, 1, 1, 1, 32'h00, 0, 32'h00);
    tbl[16] = mk(0, 1, 1, 1, 32'h04, 0, 32'h00);
    tbl[17] = mk(0, 1, 1, 1, 32'h08, 1, 32'h00);
    tbl[18] = mk(0, 0, 1, 1, 32'h0C, 1, 32'h04);
    tbl[19] = mk(0, 0, 1, 1, 32'h0C, 1, 32'h08);
    tbl[20] = mk(0, 0, 1, 1, 32'h0C, 0, 32'h00);
    tbl[21] = mk(0, 1, 1, 1, 32'h0C, 0, 32'h00);
    tbl[22] = mk(0, 1, 1, 1, 32'h10, 0, 32'h00);
    tbl[23] = mk(0, 1, 1, 1, 32'h14, 1, 32'h0C);
    tbl[24] = mk(0, 1, 1, 1, 32'h18, 1, 32'h10);

    #1;
    do_reset(3);
    lat = 1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(2);
      drive_check(1'b0, 32'h0, tbl[i].gnt, tbl[i].rdy);
      chk1($sformatf("tbl%0d req", i), mem_req,
           tbl[i].ereq);
      if (tbl[i].ereq)
        chk32($sformatf("tbl%0d addr", i), mem_addr,
              tbl[i].eaddr);
      chk1($sformatf("tbl%0d valid", i), out_valid,
           tbl[i].evld);
      if (tbl[i].evld) begin
        chk32($sformatf("tbl%0d pc", i), out_pc,
              tbl[i].epc);
        chk32($sformatf("tbl%0d instr", i), out_instr,
              memfn(tbl[i].epc));
      end
      tick();
    end

    // k=3, redirect with two fetches in flight
    do_reset(2);
    lat = 3;
    plain(3);
    drive_check(1'b1, 32'h100, 1'b1, 1'b1);
    chk1("k3 redir req", mem_req, 1'b0);
    tick();
    drive_check(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("k3 flushed", out_valid, 1'b0);
    chk32("k3 new pc", mem_addr, 32'h100);
    tick();
    wait_valid("k3 redir", 32'h100, 30);

    // redirect coincident with rvalid and pop
    do_reset(2);
    lat = 1;
    plain(4);
    drive_check(1'b1, 32'h203, 1'b1, 1'b1);
    chk1("r203 rvalid", cur_rv, 1'b1);
    chk1("r203 popping", out_valid, 1'b1);
    chk1("r203 withdrawn", mem_req, 1'b0);
    tick();
    drive_check(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("r203 flushed", out_valid, 1'b0);
    chk1("r203 req", mem_req, 1'b1);
    chk32("r203 addr", mem_addr, 32'h200);
    tick();
    wait_valid("r203", 32'h200, 20);

    // reset in the middle of a drain
    do_reset(2);
    lat = 3;
    plain(3);
    drive_check(1'b1, 32'h40, 1'b1, 1'b1);
    tick();
    do_reset(3);
    drive_check(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("rst boot req", mem_req, 1'b0);
    tick();
    drive_check(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("rst restart req", mem_req, 1'b1);
    chk32("rst restart addr", mem_addr, 32'h0);
    tick();
    wait_valid("rst restart", 32'h0, 20);

    // PC wrap at the top of the address space
    do_reset(2);
    lat = 1;
    plain(1);
    drive_check(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    tick();
    wait_valid("wrap", 32'hFFFF_FFF8, 20);
    drive_check(1'b0, 32'h0, 1'b1, 1'b1);
    chk32("wrap pc1", out_pc, 32'hFFFF_FFFC);
    chk32("wrap pc1+4", out_pc_plus_4, 32'h0);
    tick();
    drive_check(1'b0, 32'h0, 1'b1, 1'b1);
    chk32("wrap pc2", out_pc, 32'h0);
    tick();

    // random traffic against the model
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      if (i % 128 == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 599) == 0) do_reset(2);
      r = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)
        rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        rpc = $urandom;
      drive_check(r, rpc,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
